// File: rtl/ser_cmd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ser_cmd_pkg                                                  |
// | Description : Shared types for the serial command sequencer: bus command   |
// |               codes, FSM state encoding and STATUS word bit offsets.       |
// |               The PAR state exists only when SER_PARITY_EN is defined.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package ser_cmd_pkg;

   // Command codes carried on addr[7:4]
   typedef enum logic [3:0] {
      CMD_LOAD   = 4'h1,
      CMD_START  = 4'h2,
      CMD_ABORT  = 4'h3,
      CMD_STATUS = 4'h4
   } cmd_e;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
`ifdef SER_PARITY_EN
      ST_PAR   = 2'd2,
`endif
      ST_DONE  = 2'd3
   } state_e;

   // STATUS word: bit count occupies [CW-1:0]; the flags sit directly above
   // it at these offsets from CW.
   localparam int unsigned STAT_BUSY_OFS = 0;
   localparam int unsigned STAT_DONE_OFS = 1;
   localparam int unsigned STAT_OVR_OFS  = 2;

endpackage
`default_nettype wire

// File: rtl/ser_cmd_div.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ser_cmd_div                                                  |
// | Description : Bit-period prescaler. Counts DIV clocks while enabled and    |
// |               pulses bit_tick_o in the last clock of each bit period.      |
// |               clr_i restarts the period synchronously.                     |
// | Ports       : clk, rst        - clock, async active-high reset             |
// |               en_i            - count enable (transfer in progress)        |
// |               clr_i           - synchronous restart (START / ABORT)        |
// |               bit_tick_o      - end-of-bit pulse                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ser_cmd_div #(
   parameter int unsigned DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   input  logic clr_i,
   output logic bit_tick_o
);

   // One bit keeps the counter legal for DIV=1, where it simply stays at 0.
   localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             w_last;

   assign w_last     = (cnt_q == c_cnt_last);
   assign bit_tick_o = en_i & ~clr_i & w_last;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || !en_i) begin
         cnt_d = '0;
      end else if (w_last) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/ser_cmd_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ser_cmd_seq                                                  |
// | Description : Bus-controlled serial transmitter. LOAD fills the shift      |
// |               register, START sends it MSB-first on sdo at DIV clocks per  |
// |               bit, ABORT cancels, STATUS returns {ovr, done_flag, busy,    |
// |               bitcount} on rdata.                                          |
// | Config      : define SER_PARITY_EN to append an odd-parity bit (PAR state).|
// | Ports       : clk, rst  - clock, async active-high reset                   |
// |               sel_n     - active-low select                                |
// |               addr[13:0]- [13:12] page, [7:4] command                      |
// |               rw        - 1 read, 0 write                                  |
// |               strb      - single-cycle bus strobe                          |
// |               wdata     - write data (DATA_W)                              |
// |               rdata     - registered STATUS data (DATA_W)                  |
// |               sdo       - serial data out, idles high                      |
// |               busy      - transfer in progress                             |
// |               done      - one-cycle completion pulse                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ser_cmd_seq
   import ser_cmd_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DIV    = 4,
   parameter logic [1:0]  PAGE   = 2'b01
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sel_n,
   input  logic [13:0]       addr,
   input  logic              rw,
   input  logic              strb,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              sdo,
   output logic              busy,
   output logic              done
);

   localparam int unsigned CW = $clog2(DATA_W + 1);
   localparam logic [CW-1:0] c_last_bit = CW'(DATA_W - 1);

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   shreg_q, shreg_d;
   logic [CW-1:0]       bitcnt_q, bitcnt_d;
   logic                ovr_q, ovr_d;
   logic                dflag_q, dflag_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
`ifdef SER_PARITY_EN
   logic                par_q, par_d;
`endif

   logic                w_hit;
   logic [3:0]          w_cmd;
   logic                w_load, w_start, w_abort, w_status;
   logic                w_idle, w_in_done, w_busy;
   logic                w_start_acc;
   logic                w_tick;
   logic [CW+2:0]       w_stat;
   logic                unused_addr_bits;

   // ---------------------------------------------------------------- decode
   assign w_hit    = ~sel_n & strb & (addr[13:12] == PAGE);
   assign w_cmd    = addr[7:4];
   assign w_load   = w_hit & ~rw & (w_cmd == CMD_LOAD);
   assign w_start  = w_hit & ~rw & (w_cmd == CMD_START);
   assign w_abort  = w_hit & ~rw & (w_cmd == CMD_ABORT);
   assign w_status = w_hit &  rw & (w_cmd == CMD_STATUS);

   assign unused_addr_bits = ^{addr[11:8], addr[3:0]};

   assign w_idle      = (state_q == ST_IDLE);
   assign w_in_done   = (state_q == ST_DONE);
   assign w_start_acc = w_start & w_idle;

   always_comb begin
      w_busy = (state_q == ST_SHIFT);
`ifdef SER_PARITY_EN
      if (state_q == ST_PAR) begin
         w_busy = 1'b1;
      end
`endif
   end

   // ------------------------------------------------------------ prescaler
   ser_cmd_div #(
      .DIV (DIV)
   ) u_div (
      .clk        (clk),
      .rst        (rst),
      .en_i       (w_busy),
      .clr_i      (w_start_acc | w_abort),
      .bit_tick_o (w_tick)
   );

   // --------------------------------------------------------- status word
   // A read landing on the DONE cycle must already see done_flag set.
   assign w_stat[CW-1:0]             = bitcnt_q;
   assign w_stat[CW+STAT_BUSY_OFS]   = w_busy;
   assign w_stat[CW+STAT_DONE_OFS]   = dflag_q | w_in_done;
   assign w_stat[CW+STAT_OVR_OFS]    = ovr_q;

   // ------------------------------------------------------ next-state logic
   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      bitcnt_d = bitcnt_q;
      ovr_d    = ovr_q;
      dflag_d  = dflag_q;
      rdata_d  = rdata_q;
`ifdef SER_PARITY_EN
      par_d    = par_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (w_load) begin
               shreg_d = wdata;
            end
            if (w_start) begin
               state_d  = ST_SHIFT;
               bitcnt_d = '0;
`ifdef SER_PARITY_EN
               // Parity is frozen from the loaded word before it shifts out.
               par_d    = ~(^shreg_q);
`endif
            end
         end
         ST_SHIFT: begin
            if (w_tick) begin
               shreg_d  = {shreg_q[DATA_W-2:0], 1'b0};
               bitcnt_d = bitcnt_q + CW'(1);
               if (bitcnt_q == c_last_bit) begin
`ifdef SER_PARITY_EN
                  state_d = ST_PAR;
`else
                  state_d = ST_DONE;
`endif
               end
            end
         end
`ifdef SER_PARITY_EN
         ST_PAR: begin
            if (w_tick) begin
               state_d = ST_DONE;
            end
         end
`endif
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // ABORT overrides any bit boundary falling on the same edge.
      if (w_abort) begin
         state_d  = ST_IDLE;
         shreg_d  = shreg_q;
         bitcnt_d = bitcnt_q;
      end

      if (w_load && !w_idle) begin
         ovr_d = 1'b1;
      end

      if (w_in_done) begin
         dflag_d = 1'b1;
      end

      if (w_status) begin
         rdata_d = DATA_W'(w_stat);
         ovr_d   = 1'b0;
         dflag_d = 1'b0;
      end
   end

   // ------------------------------------------------------------ registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         shreg_q  <= '0;
         bitcnt_q <= '0;
         ovr_q    <= 1'b0;
         dflag_q  <= 1'b0;
         rdata_q  <= '0;
`ifdef SER_PARITY_EN
         par_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         bitcnt_q <= bitcnt_d;
         ovr_q    <= ovr_d;
         dflag_q  <= dflag_d;
         rdata_q  <= rdata_d;
`ifdef SER_PARITY_EN
         par_q    <= par_d;
`endif
      end
   end

   // -------------------------------------------------------------- outputs
   always_comb begin
      sdo = 1'b1;
      case (state_q)
         ST_SHIFT: sdo = shreg_q[DATA_W-1];
`ifdef SER_PARITY_EN
         ST_PAR:   sdo = par_q;
`endif
         default:  sdo = 1'b1;
      endcase
   end

   assign busy  = w_busy;
   assign done  = w_in_done;
   assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ser_cmd_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ser_cmd_seq                                               |
// | Description : Self-checking bench for ser_cmd_seq (DATA_W=8, DIV=4).       |
// |               A cycle-count model predicts sdo/busy/done/rdata each cycle; |
// |               directed scenarios add hand-computed literal checks.         |
// |               Honours SER_PARITY_EN.                                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ser_cmd_seq;

   localparam int DW = 8;
   localparam int DV = 4;
`ifdef SER_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int LEN    = (DW + PB) * DV;   // busy cycles per transfer
   localparam int DONE_K = LEN + 1;          // cycle of done pulse after START edge

   bit          clk;
   logic        rst   = 1'b1;
   logic        sel_n = 1'b1;
   logic [13:0] addr  = '0;
   logic        rw    = 1'b0;
   logic        strb  = 1'b0;
   logic [7:0]  wdata = '0;
   logic [7:0]  rdata;
   logic        sdo, busy, done;

   int n_assert = 0;
   int n_fail   = 0;

   ser_cmd_seq #(.DATA_W(DW), .DIV(DV), .PAGE(2'b01)) dut (
      .clk   (clk),
      .rst   (rst),
      .sel_n (sel_n),
      .addr  (addr),
      .rw    (rw),
      .strb  (strb),
      .wdata (wdata),
      .rdata (rdata),
      .sdo   (sdo),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------- model
   // A transfer is tracked only as "cycles since START edge" (m_t); every
   // output follows from that count by arithmetic.
   bit         m_active = 1'b0;
   int         m_t      = 0;
   logic [7:0] m_data   = '0;
   bit         m_ovr    = 1'b0;
   bit         m_dflag  = 1'b0;
   int         m_bits   = 0;
   logic [7:0] m_rdata  = '0;

   function automatic bit exp_busy();
      return m_active && (m_t <= LEN);
   endfunction

   function automatic bit exp_done();
      return m_active && (m_t == LEN + 1);
   endfunction

   function automatic logic exp_sdo();
      int idx;
      if (!m_active || m_t > LEN) return 1'b1;
      idx = (m_t - 1) / DV;
      if (idx < DW) return m_data[DW-1-idx];
      return ~(^m_data);
   endfunction

   function automatic int bits_now();
      int b;
      if (!m_active) return m_bits;
      if (m_t > LEN) return DW;
      b = (m_t - 1) / DV;
      return (b > DW) ? DW : b;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_active = 1'b0; m_t = 0; m_data = '0; m_ovr = 1'b0;
         m_dflag = 1'b0; m_bits = 0; m_rdata = '0;
      end else begin
         bit hit, in_done, in_idle, is_status;
         int b;
         logic [3:0] c;
         hit       = !sel_n && strb && (addr[13:12] == 2'b01);
         c         = addr[7:4];
         in_done   = exp_done();
         in_idle   = !m_active;
         b         = bits_now();
         is_status = hit && rw && (c == 4'h4);
         if (is_status)
            m_rdata = {1'b0, m_ovr, m_dflag | in_done, exp_busy(), 4'(b)};
         if (hit && !rw && c == 4'h1) begin
            if (in_idle) m_data = wdata;
            else         m_ovr  = 1'b1;
         end
         if (hit && !rw && c == 4'h3) begin
            m_active = 1'b0;
            m_bits   = b;
         end else if (m_active) begin
            if (in_done) begin
               m_active = 1'b0;
               m_bits   = DW;
            end else begin
               m_t++;
            end
         end else if (hit && !rw && c == 4'h2) begin
            m_active = 1'b1;
            m_t      = 1;
            m_bits   = 0;
         end
         if (in_done)   m_dflag = 1'b1;
         if (is_status) begin
            m_ovr   = 1'b0;
            m_dflag = 1'b0;
         end
      end
   end

   // Every cycle: DUT outputs against the model.
   always @(negedge clk) begin
      chk("sdo",   32'(sdo),   32'(exp_sdo()));
      chk("busy",  32'(busy),  32'(exp_busy()));
      chk("done",  32'(done),  32'(exp_done()));
      chk("rdata", 32'(rdata), 32'(m_rdata));
   end

   // ------------------------------------------------------------ stimulus
   task automatic bus_idle();
      sel_n = 1'b1; strb = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
   endtask

   // Called at a negedge: strobes for one cycle, returns at the next negedge.
   task automatic cmd(input logic [3:0] code, input logic r, input logic [7:0] d,
                      input logic [1:0] pg = 2'b01, input logic sn = 1'b0);
      sel_n = sn; strb = 1'b1; rw = r; wdata = d;
      addr  = {pg, 4'h0, code, 4'h0};
      @(negedge clk);
      bus_idle();
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic no_done(input int n, input string name);
      logic seen;
      seen = 1'b0;
      repeat (n) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      chk(name, 32'(seen), 32'h0);
   endtask

   // Entered at cycle 1 after a START edge. Collects the first cycle of each
   // data bit and returns the cycle number of the done pulse (-1 on timeout).
   // An optional LOAD is strobed during cycle ld_k.
   task automatic run_xfer(input int ld_k, input logic [7:0] ld_val,
                           output logic [7:0] got, output int done_k);
      got    = '0;
      done_k = -1;
      for (int k = 1; k <= 100; k++) begin
         if (k == ld_k + 1) bus_idle();
         if (k == ld_k) begin
            sel_n = 1'b0; strb = 1'b1; rw = 1'b0; wdata = ld_val;
            addr  = {2'b01, 4'h0, 4'h1, 4'h0};
         end
         if (k <= DW * DV && (k % DV) == 1) got = {got[6:0], sdo};
         if (PB == 1 && k == DW * DV + 1) chk("parity_bit", 32'(sdo), 32'h1);
         if (done) begin
            done_k = k;
            break;
         end
         @(negedge clk);
      end
      bus_idle();
   endtask

   initial begin
      logic [7:0] got;
      int         dk;

      // Reset
      repeat (3) @(negedge clk);
      chk("rst_sdo",   32'(sdo),   32'h1);
      chk("rst_busy",  32'(busy),  32'h0);
      chk("rst_done",  32'(done),  32'h0);
      chk("rst_rdata", 32'(rdata), 32'h0);
      rst = 1'b0;
      wait_cyc(2);

      // Basic transfer of 0xA5
      cmd(4'h1, 1'b0, 8'hA5);
      cmd(4'h2, 1'b0, 8'h00);
      chk("busy_after_start", 32'(busy), 32'h1);
      run_xfer(0, 8'h00, got, dk);
      chk("a5_bits",      32'(got),  32'hA5);
      chk("a5_done_cyc",  32'(dk),   32'(DONE_K));
      chk("a5_busy_done", 32'(busy), 32'h0);
      wait_cyc(1);
      cmd(4'h4, 1'b1, 8'h00);
      chk("stat_after_done", 32'(rdata), 32'h28);
      cmd(4'h4, 1'b1, 8'h00);
      chk("stat_flag_clr",   32'(rdata), 32'h08);

      // ABORT on the bit boundary closing bit 3
      cmd(4'h1, 1'b0, 8'hA5);
      cmd(4'h2, 1'b0, 8'h00);
      wait_cyc(15);
      cmd(4'h3, 1'b0, 8'h00);
      chk("abort_sdo",  32'(sdo),  32'h1);
      chk("abort_busy", 32'(busy), 32'h0);
      no_done(LEN + 8, "abort_no_done");
      cmd(4'h4, 1'b1, 8'h00);
      chk("abort_status", 32'(rdata), 32'h03);

      // LOAD during SHIFT is dropped and flags overrun
      cmd(4'h1, 1'b0, 8'h96);
      cmd(4'h2, 1'b0, 8'h00);
      run_xfer(6, 8'h3C, got, dk);
      chk("ovr_bits",     32'(got), 32'h96);
      chk("ovr_done_cyc", 32'(dk),  32'(DONE_K));
      wait_cyc(1);
      cmd(4'h4, 1'b1, 8'h00);
      chk("ovr_status1", 32'(rdata), 32'h68);
      cmd(4'h4, 1'b1, 8'h00);
      chk("ovr_status2", 32'(rdata), 32'h08);

      // Non-hit and wrong-rw STARTs are ignored
      cmd(4'h1, 1'b0, 8'hFF);
      cmd(4'h2, 1'b0, 8'h00, 2'b01, 1'b1);
      chk("selN_busy", 32'(busy), 32'h0);
      chk("selN_sdo",  32'(sdo),  32'h1);
      cmd(4'h2, 1'b0, 8'h00, 2'b10, 1'b0);
      chk("page_busy", 32'(busy), 32'h0);
      chk("page_sdo",  32'(sdo),  32'h1);
      cmd(4'h2, 1'b1, 8'h00);
      chk("rw_busy",   32'(busy), 32'h0);

      // STATUS mid-SHIFT, then reset mid-SHIFT
      cmd(4'h2, 1'b0, 8'h00);
      wait_cyc(5);
      cmd(4'h4, 1'b1, 8'h00);
      chk("mid_status", 32'(rdata), 32'h11);
      wait_cyc(3);
      #2 rst = 1'b1;
      #1;
      chk("mrst_sdo",   32'(sdo),   32'h1);
      chk("mrst_busy",  32'(busy),  32'h0);
      chk("mrst_done",  32'(done),  32'h0);
      chk("mrst_rdata", 32'(rdata), 32'h0);
      wait_cyc(2);
      rst = 1'b0;
      no_done(LEN + 8, "mrst_no_done");

      // STATUS landing on the DONE cycle
      cmd(4'h1, 1'b0, 8'h01);
      cmd(4'h2, 1'b0, 8'h00);
      wait_cyc(DONE_K - 1);
      chk("coinc_done", 32'(done), 32'h1);
      cmd(4'h4, 1'b1, 8'h00);
      chk("coinc_status1", 32'(rdata), 32'h28);
      cmd(4'h4, 1'b1, 8'h00);
      chk("coinc_status2", 32'(rdata), 32'h08);

      wait_cyc(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
